// File: rtl/pmem_line_responder_pkg.sv
// ----------------------------------------------------------------------------
// lc3b_types: shared types for the cache-to-physical-memory line interface.
//   lc3b_pmem_line   - one 128-bit memory line
//   lc3b_pmem_index  - line index taken from address bits [15:4]
//   PMEM_OFFSET_BITS - byte-offset bits within a line (ignored by memory)
//   pmem_state_t     - responder FSM states
// ----------------------------------------------------------------------------
package lc3b_types;

  localparam int PMEM_OFFSET_BITS = 4;

  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [11:0]  lc3b_pmem_index;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_array.sv
// ----------------------------------------------------------------------------
// pmem_line_array: synchronous-write, synchronous-read line store.
//   clk   - clock
//   we    - write enable; wdata is stored at index on the rising edge
//   index - line index shared by read and write
//   wdata - line to write
//   rdata - registered read of store[index] (read-before-write on a collision)
// ----------------------------------------------------------------------------
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int INDEX_BITS = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  lc3b_pmem_line         wdata,
  output lc3b_pmem_line         rdata
);

  lc3b_pmem_line mem [2**INDEX_BITS];
  lc3b_pmem_line rdata_q;

  // NOTE: the store has no reset so it can map onto block RAM; only control
  // state needs a defined value after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata_q <= mem[index];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// ----------------------------------------------------------------------------
// pmem_line_responder: responder end of the pmem_* line interface. Accepts a
// line read or write, answers after LATENCY cycles with a one-cycle pmem_resp,
// and raises a sticky proto_err on initiator handshake violations.
//   clk, rst_n   - clock, synchronous active-low reset
//   pmem_read    - line read request, held until pmem_resp
//   pmem_write   - line write request, held until pmem_resp
//   pmem_address - byte address; [15:4] selects the line
//   pmem_wdata   - write line data
//   pmem_resp    - one-cycle completion pulse
//   pmem_rdata   - read line data, valid during pmem_resp, held afterwards
//   proto_err    - sticky protocol-violation flag
// ----------------------------------------------------------------------------
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  logic [15:0]   pmem_address,
  input  lc3b_pmem_line pmem_wdata,
  output logic          pmem_resp,
  output lc3b_pmem_line pmem_rdata,
  output logic          proto_err
);

  pmem_state_t           state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [1:0]            req_q, req_d;      // {read, write} as seen at acceptance
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  lc3b_pmem_line         wdata_q, wdata_d;
  logic                  resp_q, resp_d;
  lc3b_pmem_line         rhold_q, rhold_d;
  logic                  err_q, err_d;

  logic [INDEX_BITS-1:0] addr_idx;
  logic [INDEX_BITS-1:0] arr_index;
  logic                  arr_we;
  lc3b_pmem_line         arr_rdata;
  logic                  unused_addr;

  assign addr_idx    = pmem_address[PMEM_OFFSET_BITS +: INDEX_BITS];
  assign unused_addr = ^pmem_address[PMEM_OFFSET_BITS-1:0];

  // In IDLE the store looks up the incoming address so a LATENCY=1 read has
  // its line ready on the acceptance edge; afterwards the latched index wins.
  assign arr_index = (state_q == IDLE) ? addr_idx : idx_q;

  // Commit on the edge leaving RESP; a reset on that edge aborts the write.
  assign arr_we = (state_q == RESP) && op_wr_q && rst_n;

  pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (arr_index),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    req_d   = req_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    resp_d  = 1'b0;
    rhold_d = rhold_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          op_wr_d = pmem_write;             // write wins when both are high
          req_d   = {pmem_read, pmem_write};
          idx_d   = addr_idx;
          wdata_d = pmem_wdata;
          cnt_d   = 8'(LATENCY - 1);
          if (pmem_read && pmem_write) err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            resp_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
          resp_d  = 1'b1;
        end
        if ({pmem_read, pmem_write} != req_q || addr_idx != idx_q) err_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (!op_wr_q) rhold_d = arr_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      req_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rhold_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rhold_q <= rhold_d;
      err_q   <= err_d;
    end
  end

  assign pmem_resp = resp_q;
  assign proto_err = err_q;
  // During a read's RESP cycle the store's registered output already holds
  // the line; afterwards the copy captured when leaving RESP is shown.
  assign pmem_rdata = (state_q == RESP && !op_wr_q) ? arr_rdata : rhold_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;
  import lc3b_types::*;

  localparam lc3b_pmem_line D0 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam lc3b_pmem_line D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam lc3b_pmem_line D2 = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
  localparam lc3b_pmem_line D3 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam lc3b_pmem_line D5 = 128'h11111111_22222222_33333333_44444444;
  localparam lc3b_pmem_line D6 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam lc3b_pmem_line D7 = 128'hCAFEF00D_00000000_FFFFFFFF_0BADC0DE;
  localparam lc3b_pmem_line D8 = 128'h87654321_0FEDCBA9_13579BDF_2468ACE0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd0, wr0, rd1, wr1;
  logic [15:0] a0, a1;
  lc3b_pmem_line wd0, wd1, rdata0, rdata1;
  logic resp0, resp1, err0, err1;

  pmem_line_responder #(.LATENCY(10), .INDEX_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd0), .pmem_write(wr0),
    .pmem_address(a0), .pmem_wdata(wd0), .pmem_resp(resp0),
    .pmem_rdata(rdata0), .proto_err(err0)
  );

  pmem_line_responder #(.LATENCY(1), .INDEX_BITS(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(a1), .pmem_wdata(wd1), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .proto_err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic rd, input logic wr,
                       input logic [15:0] a, input lc3b_pmem_line d);
    if (u == 0) begin rd0 = rd; wr0 = wr; a0 = a; wd0 = d; end
    else        begin rd1 = rd; wr1 = wr; a1 = a; wd1 = d; end
  endtask

  function automatic logic resp_of(input int u);
    return (u == 0) ? resp0 : resp1;
  endfunction

  function automatic lc3b_pmem_line rdata_of(input int u);
    return (u == 0) ? rdata0 : rdata1;
  endfunction

  // One full transaction. Latency counts falling edges after the acceptance
  // edge up to the one that sees pmem_resp. drop_at != 0 releases the request
  // at that falling edge to provoke a mid-BUSY violation.
  task automatic txn(input int u, input string tag, input logic rd, input logic wr,
                     input logic [15:0] a, input lc3b_pmem_line d, input int drop_at,
                     input int exp_lat, output lc3b_pmem_line rdata);
    int k;
    k = 0;
    @(negedge clk);
    drive(u, rd, wr, a, d);
    do begin
      @(negedge clk);
      k++;
      if (drop_at != 0 && k == drop_at) drive(u, 1'b0, 1'b0, a, d);
    end while (!resp_of(u) && k < 200);
    check({tag, " latency"}, 128'(k), 128'(exp_lat));
    rdata = rdata_of(u);
    drive(u, 1'b0, 1'b0, a, d);
    @(negedge clk);
    check({tag, " pulse width"}, 128'(resp_of(u)), 128'(0));
  endtask

  initial begin
    lc3b_pmem_line r;
    int hits;
    int g;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, '0);
    drive(1, 1'b0, 1'b0, 16'h0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp0 || resp1) hits++;
    end
    check("idle resp", 128'(hits), 128'(0));
    check("reset rdata", rdata0, '0);
    check("reset err", 128'(err0), 128'(0));

    // Write then read, offset ignored, wrap, rdata hold across writes
    txn(0, "wr 0000", 1'b0, 1'b1, 16'h0000, D0, 0, 10, r);
    txn(0, "wr 1234", 1'b0, 1'b1, 16'h1234, D1, 0, 10, r);
    txn(0, "rd 123A", 1'b1, 1'b0, 16'h123A, '0, 0, 10, r);
    check("rd 123A data", r, D1);
    txn(0, "wr FFF0", 1'b0, 1'b1, 16'hFFF0, D2, 0, 10, r);
    check("rdata held over write", rdata0, D1);
    txn(0, "rd FFFF", 1'b1, 1'b0, 16'hFFFF, '0, 0, 10, r);
    check("rd FFFF data", r, D2);
    txn(0, "rd 0000", 1'b1, 1'b0, 16'h0000, '0, 0, 10, r);
    check("rd 0000 data", r, D0);

    // Back-to-back: read held high through pmem_resp
    txn(0, "wr 0040", 1'b0, 1'b1, 16'h0040, D3, 0, 10, r);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0040, '0);
    g = 0;
    do begin @(negedge clk); g++; end while (!resp0 && g < 200);
    check("b2b first latency", 128'(g), 128'(10));
    check("b2b first data", rdata0, D3);
    g = 0;
    do begin @(negedge clk); g++; end while (!resp0 && g < 200);
    check("b2b second gap", 128'(g), 128'(11));
    check("b2b second data", rdata0, D3);
    drive(0, 1'b0, 1'b0, 16'h0, '0);
    @(negedge clk);
    check("b2b err", 128'(err0), 128'(0));

    // Reset in the middle of a write
    txn(0, "wr 0100", 1'b0, 1'b1, 16'h0100, D5, 0, 10, r);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0100, D6);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp0) hits++;
    end
    check("aborted resp", 128'(hits), 128'(0));
    txn(0, "rd 0100", 1'b1, 1'b0, 16'h0100, '0, 0, 10, r);
    check("rd 0100 old data", r, D5);
    check("err after abort", 128'(err0), 128'(0));

    // Read and write high together: write performed, error flagged
    txn(0, "both 0200", 1'b1, 1'b1, 16'h0200, D7, 0, 10, r);
    check("both err", 128'(err0), 128'(1));
    txn(0, "rd 0200", 1'b1, 1'b0, 16'h0200, '0, 0, 10, r);
    check("rd 0200 data", r, D7);
    check("err sticky", 128'(err0), 128'(1));

    // Fresh reset, then drop the read mid-BUSY
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("err cleared", 128'(err0), 128'(0));
    check("rdata cleared", rdata0, '0);
    txn(0, "drop 0040", 1'b1, 1'b0, 16'h0040, '0, 4, 10, r);
    check("drop data", r, D3);
    check("drop err", 128'(err0), 128'(1));

    // LATENCY = 1 instance
    txn(1, "l1 wr 0010", 1'b0, 1'b1, 16'h0010, D8, 0, 1, r);
    txn(1, "l1 rd 0018", 1'b1, 1'b0, 16'h0018, '0, 0, 1, r);
    check("l1 rd data", r, D8);
    check("l1 err", 128'(err1), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
